// File: rtl/limn2600_icache_refill.sv
// Limn2600 I-cache refill engine: fetches one line critical-word-first
// from the memory bus and streams it into the cache write port.
module limn2600_icache_refill #(
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_valid,
   input  logic [31:0] miss_addr,
   output logic        miss_ready,
   output logic        crit_valid,
   output logic        fill_done,
   output logic        fill_err,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err,
   output logic        cache_we,
   output logic [31:0] cache_addr,
   output logic [31:0] cache_wdata
);

   localparam int IW = $clog2(LINE_WORDS);
   localparam int BW = IW + 1;
   localparam logic [31:0] LMASK = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WR,
      DONE,
      ERR
   } state_t;

   state_t        state, state_n;
   logic [31:0]   base, base_n;
   logic [31:0]   data, data_n;
   logic [IW-1:0] idx, idx_n;
   logic [BW-1:0] beats, beats_n;
   logic [15:0]   wcnt, wcnt_n;
   logic [31:0]   word_addr;

   // idx wraps inside the line, so the sum never leaves it
   assign word_addr = base + {{(30-IW){1'b0}}, idx, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
         data  <= '0;
         idx   <= '0;
         beats <= '0;
         wcnt  <= '0;
      end else begin
         state <= state_n;
         base  <= base_n;
         data  <= data_n;
         idx   <= idx_n;
         beats <= beats_n;
         wcnt  <= wcnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      base_n      = base;
      data_n      = data;
      idx_n       = idx;
      beats_n     = beats;
      wcnt_n      = wcnt;
      miss_ready  = 1'b0;
      crit_valid  = 1'b0;
      fill_done   = 1'b0;
      fill_err    = 1'b0;
      bus_req     = 1'b0;
      bus_addr    = '0;
      cache_we    = 1'b0;
      cache_addr  = '0;
      cache_wdata = '0;
      unique case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               base_n  = miss_addr & ~LMASK;
               idx_n   = miss_addr[IW+1:2];
               beats_n = '0;
               wcnt_n  = '0;
               state_n = REQ;
            end
         end
         REQ: begin
            bus_req  = 1'b1;
            bus_addr = word_addr;
            if (bus_err) begin
               state_n = ERR;
            end else if (bus_ack) begin
               data_n  = bus_rdata;
               state_n = WR;
            end else if (wcnt == 16'(TIMEOUT - 1)) begin
               state_n = ERR;
            end else begin
               wcnt_n = wcnt + 16'd1;
            end
         end
         WR: begin
            cache_we    = 1'b1;
            cache_addr  = word_addr;
            cache_wdata = data;
            crit_valid  = (beats == '0);
            idx_n       = idx + 1'b1;
            beats_n     = beats + 1'b1;
            wcnt_n      = '0;
            state_n     = (beats_n == BW'(LINE_WORDS)) ? DONE : REQ;
         end
         DONE: begin
            fill_done = 1'b1;
            state_n   = IDLE;
         end
         ERR: begin
            fill_err = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // a reset cycle must never leak a write or a pulse
      if (rst) begin
         crit_valid  = 1'b0;
         fill_done   = 1'b0;
         fill_err    = 1'b0;
         bus_req     = 1'b0;
         bus_addr    = '0;
         cache_we    = 1'b0;
         cache_addr  = '0;
         cache_wdata = '0;
      end
   end

endmodule
